// File: rtl/pm_loader_pkg.sv
// Shared types and constants for the program-memory loader.
package pm_loader_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADD_WIDTH  = 7;
    localparam int DEF_WIDTH      = 8;

    // Flops in each pad synchronizer chain.
    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        RUN   = 2'd3
    } state_t;

    // Bytes per instruction word; data width must be a multiple of the pad width.
    function automatic int calc_bpw(input int data_width, input int width);
        return data_width / width;
    endfunction

endpackage

// File: rtl/pm_loader_if.sv
// Pad-side inputs and program-memory/CPU-side outputs of the loader.
interface pm_loader_if
    import pm_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADD_WIDTH  = DEF_ADD_WIDTH,
    parameter int WIDTH      = DEF_WIDTH
);
    logic                  load_en;
    logic                  byte_strobe;
    logic [WIDTH-1:0]      byte_in;
    logic                  pm_wr_en;
    logic [ADD_WIDTH-1:0]  pm_addr;
    logic [DATA_WIDTH-1:0] pm_wdata;
    logic                  cpu_rst_n;
    logic [ADD_WIDTH:0]    word_count;
    logic                  full;

    // Pad / environment side.
    modport master (
        output load_en, byte_strobe, byte_in,
        input  pm_wr_en, pm_addr, pm_wdata, cpu_rst_n, word_count, full
    );

    // Loader side.
    modport slave (
        input  load_en, byte_strobe, byte_in,
        output pm_wr_en, pm_addr, pm_wdata, cpu_rst_n, word_count, full
    );
endinterface

// File: rtl/pm_loader_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit pad.
module sync_2ff
    import pm_loader_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] chain;

    // Shift the pad level through the metastability chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so every
            // flop samples the pre-edge value of its neighbour.
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];
endmodule

// File: rtl/pm_loader.sv
// Program-memory loader: assembles pad bytes into words, writes them at an
// auto-incrementing address and holds the CPU in reset while loading.
module pm_loader
    import pm_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADD_WIDTH  = DEF_ADD_WIDTH,
    parameter int WIDTH      = DEF_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    pm_loader_if.slave   bus
);
    localparam int BPW   = calc_bpw(DATA_WIDTH, WIDTH);
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CNT_W-1:0]     LAST_BYTE = CNT_W'(BPW - 1);
    localparam logic [ADD_WIDTH-1:0] LAST_ADDR = '1;

    logic load_en_s;
    logic strobe_s;
    logic strobe_d;
    logic byte_event;

    state_t state;
    state_t next_state;

    logic take_byte;
    logic commit_write;
    logic drop_partial;
    logic clear_session;

    logic [CNT_W-1:0]      byte_cnt;
    logic [DATA_WIDTH-1:0] word_q;
    logic [ADD_WIDTH-1:0]  addr_q;
    logic [ADD_WIDTH:0]    count_q;
    logic                  full_q;
    logic                  wr_en_q;
    logic                  cpu_rst_n_q;

    sync_2ff u_sync_load_en (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.load_en),
        .q     (load_en_s)
    );

    sync_2ff u_sync_strobe (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.byte_strobe),
        .q     (strobe_s)
    );

    assign byte_event = strobe_s & ~strobe_d;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HOLD;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        next_state    = state;
        take_byte     = 1'b0;
        commit_write  = 1'b0;
        drop_partial  = 1'b0;
        clear_session = 1'b0;
        unique case (state)
            HOLD: begin
                next_state = load_en_s ? LOAD : RUN;
            end
            LOAD: begin
                // Leaving load mode wins over a coincident byte.
                if (!load_en_s) begin
                    next_state   = RUN;
                    drop_partial = 1'b1;
                end else if (byte_event && !full_q) begin
                    take_byte = 1'b1;
                    if (byte_cnt == LAST_BYTE) begin
                        next_state = WRITE;
                    end
                end
            end
            WRITE: begin
                // The write always completes before load mode can end.
                commit_write = 1'b1;
                next_state   = load_en_s ? LOAD : RUN;
            end
            RUN: begin
                if (load_en_s) begin
                    next_state    = LOAD;
                    clear_session = 1'b1;
                end
            end
            default: next_state = HOLD;
        endcase
    end

    // Word assembly, address/count bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_d    <= 1'b0;
            byte_cnt    <= '0;
            word_q      <= '0;
            addr_q      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            strobe_d <= strobe_s;

            if (clear_session) begin
                addr_q   <= '0;
                count_q  <= '0;
                byte_cnt <= '0;
                full_q   <= 1'b0;
            end

            if (drop_partial) begin
                byte_cnt <= '0;
            end

            // Little-endian assembly: each new byte enters at the top and the
            // first byte of a word ends up in the lowest lane.
            if (take_byte) begin
                word_q   <= DATA_WIDTH'({bus.byte_in, word_q} >> WIDTH);
                byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + CNT_W'(1);
            end

            // Address wraps naturally; the last slot raises the sticky full flag.
            if (commit_write) begin
                addr_q  <= addr_q + ADD_WIDTH'(1);
                count_q <= count_q + (ADD_WIDTH + 1)'(1);
                if (addr_q == LAST_ADDR) begin
                    full_q <= 1'b1;
                end
            end

            // Write strobe is high exactly while the state register holds WRITE.
            wr_en_q     <= (next_state == WRITE);
            // CPU leaves reset one cycle after RUN is entered and drops on exit.
            cpu_rst_n_q <= (state == RUN) && (next_state == RUN);
        end
    end

    assign bus.pm_wr_en   = wr_en_q;
    assign bus.pm_addr    = addr_q;
    assign bus.pm_wdata   = word_q;
    assign bus.cpu_rst_n  = cpu_rst_n_q;
    assign bus.word_count = count_q;
    assign bus.full       = full_q;

endmodule
